// File: rtl/keccak_pkg.sv
// Shared Keccak geometry, absorb-controller widths and FSM state encodings.
package keccak_pkg;
    localparam int ROW_SIZE          = 5;
    localparam int COL_SIZE          = 5;
    localparam int LANE_SIZE         = 64;
    localparam int BEAT_BYTES        = LANE_SIZE / 8;
    localparam int RATE_WIDTH        = 11;
    localparam int BYTE_ABSORB_WIDTH = 8;
    localparam int SUFFIX_WIDTH      = 8;

    typedef logic [2:0] absorb_state_e;

    localparam absorb_state_e ST_IDLE       = 3'd0;
    localparam absorb_state_e ST_ABSORB     = 3'd1;
    localparam absorb_state_e ST_PERM       = 3'd2;
    localparam absorb_state_e ST_PAD        = 3'd3;
    localparam absorb_state_e ST_PERM_FINAL = 3'd4;
    localparam absorb_state_e ST_DONE       = 3'd5;
endpackage

// File: rtl/keccak_byte_mask.sv
// Byte-enable mask for a beat: bytes [0, nbytes) set to 0xFF, the rest zero.
// Purely combinational.
module keccak_byte_mask
    import keccak_pkg::*;
(
    input  logic [3:0]           nbytes,
    output logic [LANE_SIZE-1:0] mask
);
    always_comb begin
        mask = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (4'(i) < nbytes) mask[i*8 +: 8] = 8'hFF;
        end
    end
endmodule

// File: rtl/keccak_absorb_ctrl.sv
// Keccak sponge absorb sequencer: beat -> lane XOR writes, permutation per full block, pad + final permutation.
// Optional KECCAK_ABSORB_PERF_EN adds saturating block/busy-cycle counters.
module keccak_absorb_ctrl
    import keccak_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [RATE_WIDTH-1:0]        rate_i,
    input  logic [SUFFIX_WIDTH-1:0]      suffix_i,
    input  logic                         msg_valid_i,
    output logic                         msg_ready_o,
    input  logic [LANE_SIZE-1:0]         msg_data_i,
    input  logic [3:0]                   msg_nbytes_i,
    input  logic                         msg_last_i,
    output logic                         lane_we_o,
    output logic [4:0]                   lane_idx_o,
    output logic [LANE_SIZE-1:0]         lane_data_o,
    output logic [BYTE_ABSORB_WIDTH-1:0] bytes_absorbed_o,
    output logic [RATE_WIDTH-1:0]        rate_o,
    output logic [SUFFIX_WIDTH-1:0]      suffix_o,
    output logic                         pad_we_o,
    output logic                         perm_start_o,
    input  logic                         perm_done_i,
    output logic                         busy_o,
    output logic                         done_o
`ifdef KECCAK_ABSORB_PERF_EN
    ,
    output logic [15:0]                  blocks_o,
    output logic [31:0]                  cycles_o
`endif
);
    absorb_state_e                state;
    logic [BYTE_ABSORB_WIDTH-1:0] bytes_q;
    logic                         last_seen;
    logic                         pend;
    logic [LANE_SIZE-1:0]         mask;
    logic [BYTE_ABSORB_WIDTH:0]   bytes_next;
    logic [BYTE_ABSORB_WIDTH:0]   rate_bytes;
    logic                         block_full;

    keccak_byte_mask u_mask (
        .nbytes (msg_nbytes_i),
        .mask   (mask)
    );

    assign bytes_next       = {1'b0, bytes_q} + (BYTE_ABSORB_WIDTH+1)'(msg_nbytes_i);
    assign rate_bytes       = (BYTE_ABSORB_WIDTH+1)'(rate_o >> 3);
    assign block_full       = (bytes_next == rate_bytes);
    assign bytes_absorbed_o = bytes_q;
    assign msg_ready_o      = (state == ST_ABSORB);
    assign busy_o           = (state != ST_IDLE);

    // pend delays perm_start/pad_we one cycle so the preceding lane write lands in the state first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bytes_q      <= '0;
            rate_o       <= '0;
            suffix_o     <= '0;
            last_seen    <= 1'b0;
            pend         <= 1'b0;
            lane_we_o    <= 1'b0;
            lane_idx_o   <= '0;
            lane_data_o  <= '0;
            pad_we_o     <= 1'b0;
            perm_start_o <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            lane_we_o    <= 1'b0;
            pad_we_o     <= 1'b0;
            perm_start_o <= 1'b0;
            done_o       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        rate_o    <= rate_i;
                        suffix_o  <= suffix_i;
                        bytes_q   <= '0;
                        last_seen <= 1'b0;
                        pend      <= 1'b0;
                        state     <= ST_ABSORB;
                    end
                end
                ST_ABSORB: begin
                    if (msg_valid_i) begin
                        lane_we_o   <= (msg_nbytes_i != 4'd0);
                        lane_idx_o  <= bytes_q[BYTE_ABSORB_WIDTH-1:3];
                        lane_data_o <= msg_data_i & mask;
                        bytes_q     <= bytes_next[BYTE_ABSORB_WIDTH-1:0];
                        last_seen   <= msg_last_i;
                        if (block_full) begin
                            pend  <= 1'b1;
                            state <= ST_PERM;
                        end else if (msg_last_i) begin
                            pend  <= 1'b1;
                            state <= ST_PAD;
                        end
                    end
                end
                ST_PERM: begin
                    if (pend) begin
                        perm_start_o <= 1'b1;
                        pend         <= 1'b0;
                    end else if (perm_done_i) begin
                        bytes_q <= '0;
                        if (last_seen) begin
                            pend  <= 1'b1;
                            state <= ST_PAD;
                        end else begin
                            state <= ST_ABSORB;
                        end
                    end
                end
                ST_PAD: begin
                    if (pend) begin
                        pad_we_o <= 1'b1;
                        pend     <= 1'b0;
                    end else begin
                        perm_start_o <= 1'b1;
                        state        <= ST_PERM_FINAL;
                    end
                end
                ST_PERM_FINAL: begin
                    if (perm_done_i) begin
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef KECCAK_ABSORB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start_i)) begin
            blocks_o <= '0;
            cycles_o <= '0;
        end else begin
            if (perm_start_o && blocks_o != 16'hFFFF) blocks_o <= blocks_o + 16'd1;
            if (busy_o && cycles_o != 32'hFFFF_FFFF) cycles_o <= cycles_o + 32'd1;
        end
    end
`endif
endmodule
